// File: rtl/card_row_render_pkg.sv
// card_row_render_pkg: shared card geometry, code encoding and helpers
package card_row_render_pkg;
  localparam int CARD_W = 32;
  localparam int CARD_H = 46;
  typedef logic [5:0] code_t;
  localparam code_t CODE_BG = 6'd54;
  localparam code_t CODE_FACE_A = 6'd52;
  localparam code_t CODE_FACE_B = 6'd53;
  typedef enum logic [1:0] {SUIT_CLUB, SUIT_DIAMOND, SUIT_HEART, SUIT_SPADE} suit_e;
  function automatic code_t card_code(suit_e s, logic [3:0] rank);
    return code_t'(6'(s) * 6'd13 + 6'(rank));
  endfunction
endpackage

// File: rtl/card_hand_buf.sv
// card_hand_buf: shadow/active hand buffers with commit and frame-boundary copy
module card_hand_buf
  import card_row_render_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  code_t            wr_card,
  input  logic [4:0]       cnt_in,
  input  logic             commit,
  input  logic             swap,
  output code_t [15:0]     active,
  output logic  [4:0]      active_cnt,
  output logic             busy
);
  code_t [15:0] shadow_q, shadow_d, active_q, active_d;
  logic [4:0] shadow_cnt_q, shadow_cnt_d, active_cnt_q, active_cnt_d;
  logic busy_q, busy_d, do_copy;
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_idx] = wr_card;
    do_copy = busy_q & swap;
    shadow_cnt_d = commit ? (cnt_in > 5'd16 ? 5'd16 : cnt_in) : shadow_cnt_q;
    active_d = do_copy ? shadow_d : active_q;
    active_cnt_d = do_copy ? shadow_cnt_q : active_cnt_q;
    busy_d = commit | (busy_q & ~swap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      shadow_cnt_q <= '0;
      active_cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      shadow_cnt_q <= shadow_cnt_d;
      active_cnt_q <= active_cnt_d;
      busy_q <= busy_d;
    end
  end
  assign active = active_q;
  assign active_cnt = active_cnt_q;
  assign busy = busy_q;
endmodule

// File: rtl/card_row_render.sv
// card_row_render: renders a row of card slots as ROM lookups in a 3-cycle pixel pipeline
module card_row_render
  import card_row_render_pkg::*;
#(
  parameter int unsigned X0    = 64,
  parameter int unsigned Y0    = 400,
  parameter int unsigned PITCH = 36,
  parameter int unsigned SLOTS = 16
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        video_valid,
  input  logic        hand_wr_en,
  input  logic [3:0]  hand_wr_idx,
  input  logic [5:0]  hand_wr_card,
  input  logic [4:0]  hand_cnt,
  input  logic        hand_commit,
  output logic        commit_busy,
  output logic [5:0]  pixel_x,
  output logic [5:0]  pixel_y,
  output logic [5:0]  card_type,
  input  logic [11:0] card_pixel,
  output logic [11:0] rgb,
  output logic        rgb_valid
);
  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + PITCH * SLOTS);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + CARD_H);
  localparam logic [5:0] COL_MAX = 6'(PITCH - 1);
  localparam logic [5:0] COL_VIS = 6'(CARD_W);
  localparam logic [3:0] SLOT_MAX = 4'(SLOTS - 1);
  code_t [15:0] active;
  logic [4:0] active_cnt;
  logic [5:0] col_q, col_d, px_q, px_d, py_q, py_d;
  logic [3:0] slot_q, slot_d;
  code_t ct_q, ct_d;
  logic [11:0] rgb_q, rgb_d;
  logic v1_q, v2_q, v3_q, at_x0, wrap, in_card, swap;
  card_hand_buf u_buf (
    .clk        (clk_25MHz),
    .rst        (rst),
    .wr_en      (hand_wr_en),
    .wr_idx     (hand_wr_idx),
    .wr_card    (hand_wr_card),
    .cnt_in     (hand_cnt),
    .commit     (hand_commit),
    .swap       (swap),
    .active     (active),
    .active_cnt (active_cnt),
    .busy       (commit_busy)
  );
  always_comb begin
    swap = v_cnt == 10'd480 && h_cnt == 10'd0;
    at_x0 = h_cnt == X_LO;
    wrap = col_q == COL_MAX;
    col_d = at_x0 || wrap ? '0 : col_q + 6'd1;
    slot_d = at_x0 ? '0 : wrap && slot_q != SLOT_MAX ? slot_q + 4'd1 : slot_q;
    in_card = video_valid && v_cnt >= Y_LO && v_cnt < Y_HI && h_cnt >= X_LO && h_cnt < X_HI &&
              col_d < COL_VIS && {1'b0, slot_d} < active_cnt;
    px_d = in_card ? col_d : '0;
    py_d = in_card ? 6'(v_cnt - Y_LO) : '0;
    ct_d = in_card ? active[slot_d] : CODE_BG;
    rgb_d = v2_q ? card_pixel : '0;
  end
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      col_q <= '0;
      slot_q <= '0;
      px_q <= '0;
      py_q <= '0;
      ct_q <= CODE_BG;
      rgb_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      col_q <= col_d;
      slot_q <= slot_d;
      px_q <= px_d;
      py_q <= py_d;
      ct_q <= ct_d;
      rgb_q <= rgb_d;
      v1_q <= video_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end
  assign pixel_x = px_q;
  assign pixel_y = py_q;
  assign card_type = ct_q;
  assign rgb = rgb_q;
  assign rgb_valid = v3_q;
endmodule

// File: tb/tb_card_row_render.sv
// tb_card_row_render: directed self-checking bench with a registered ROM model
module tb_card_row_render;
  logic clk_25MHz = 1'b0;
  logic rst = 1'b1;
  logic [9:0] h_cnt = '0, v_cnt = '0;
  logic video_valid = 1'b0;
  logic hand_wr_en = 1'b0;
  logic [3:0] hand_wr_idx = '0;
  logic [5:0] hand_wr_card = '0;
  logic [4:0] hand_cnt = '0;
  logic hand_commit = 1'b0;
  logic commit_busy;
  logic [5:0] pixel_x, pixel_y, card_type;
  logic [11:0] card_pixel = '0;
  logic [11:0] rgb;
  logic rgb_valid;
  int n_chk = 0, n_err = 0;
  int m_codes[16];
  int m_cnt = 0;
  logic [11:0] s1_rgb = '0, s2_rgb = '0;
  logic s1_v = 1'b0, s2_v = 1'b0;
  card_row_render dut (
    .clk_25MHz    (clk_25MHz),
    .rst          (rst),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .video_valid  (video_valid),
    .hand_wr_en   (hand_wr_en),
    .hand_wr_idx  (hand_wr_idx),
    .hand_wr_card (hand_wr_card),
    .hand_cnt     (hand_cnt),
    .hand_commit  (hand_commit),
    .commit_busy  (commit_busy),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .card_type    (card_type),
    .card_pixel   (card_pixel),
    .rgb          (rgb),
    .rgb_valid    (rgb_valid)
  );
  always #20 clk_25MHz = ~clk_25MHz;
  function automatic logic [11:0] rom_f(logic [5:0] ct, logic [5:0] px, logic [5:0] py);
    return ct == 6'd54 ? 12'h68A : ct > 6'd54 ? 12'hFFF : {ct, px ^ py};
  endfunction
  always @(posedge clk_25MHz) card_pixel <= rom_f(card_type, pixel_x, pixel_y);
  function automatic bit in_card(int h, int v, bit vv);
    return vv && v >= 400 && v < 446 && h >= 64 && h < 640 && (h - 64) % 36 < 32 && (h - 64) / 36 < m_cnt;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int h, int v, bit vv);
    logic [5:0] ect, epx, epy;
    bit ein;
    string t;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    video_valid = vv;
    ein = in_card(h, v, vv);
    ect = ein ? 6'(m_codes[(h - 64) / 36]) : 6'd54;
    epx = ein ? 6'((h - 64) % 36) : 6'd0;
    epy = ein ? 6'(v - 400) : 6'd0;
    @(posedge clk_25MHz);
    #1;
    hand_wr_en = 1'b0;
    hand_commit = 1'b0;
    t = $sformatf("h%0d v%0d", h, v);
    check({"card_type ", t}, card_type, ect);
    check({"pixel_x ", t}, pixel_x, epx);
    check({"pixel_y ", t}, pixel_y, epy);
    check({"rgb ", t}, rgb, s2_rgb);
    check({"rgb_valid ", t}, rgb_valid, s2_v);
    s2_rgb = s1_rgb;
    s2_v = s1_v;
    s1_rgb = vv ? rom_f(ect, epx, epy) : 12'h000;
    s1_v = vv;
  endtask
  task automatic line(int v, bit vv);
    for (int h = 56; h <= 660; h++) step(h, v, vv);
  endtask
  task automatic idle(int n);
    repeat (n) step(700, 500, 1'b0);
  endtask
  task automatic wr(int idx, int code);
    hand_wr_en = 1'b1;
    hand_wr_idx = 4'(idx);
    hand_wr_card = 6'(code);
    idle(1);
  endtask
  task automatic cm(int n);
    hand_cnt = 5'(n);
    hand_commit = 1'b1;
    idle(1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    video_valid = 1'b0;
    repeat (2) @(posedge clk_25MHz);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    s1_rgb = '0;
    s2_rgb = '0;
    s1_v = 1'b0;
    s2_v = 1'b0;
    check("rst busy", commit_busy, 0);
    check("rst card_type", card_type, 54);
    check("rst pixel_x", pixel_x, 0);
    check("rst pixel_y", pixel_y, 0);
    check("rst rgb", rgb, 0);
    check("rst rgb_valid", rgb_valid, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) m_codes[i] = 0;
    do_reset();
    idle(2);
    line(399, 1'b1);
    line(400, 1'b1);
    line(445, 1'b1);
    line(400, 1'b0);
    line(446, 1'b1);
    wr(0, 5);
    wr(1, 20);
    cm(2);
    check("busy after commit", commit_busy, 1);
    line(400, 1'b1);
    step(0, 480, 1'b0);
    check("busy after swap", commit_busy, 0);
    m_codes[0] = 5;
    m_codes[1] = 20;
    m_cnt = 2;
    line(400, 1'b1);
    line(410, 1'b1);
    line(445, 1'b1);
    wr(2, 40);
    hand_cnt = 5'd3;
    hand_commit = 1'b1;
    line(200, 1'b1);
    check("busy mid-frame", commit_busy, 1);
    line(400, 1'b1);
    check("busy held to 480", commit_busy, 1);
    step(0, 480, 1'b0);
    check("busy cleared 480", commit_busy, 0);
    m_codes[2] = 40;
    m_cnt = 3;
    line(400, 1'b1);
    wr(3, 11);
    for (int i = 4; i < 16; i++) wr(i, i == 5 ? 60 : i * 3);
    cm(5);
    check("busy first commit", commit_busy, 1);
    cm(20);
    check("busy recommit", commit_busy, 1);
    hand_wr_en = 1'b1;
    hand_wr_idx = 4'd3;
    hand_wr_card = 6'd33;
    step(0, 480, 1'b0);
    check("busy after full swap", commit_busy, 0);
    m_codes[3] = 33;
    for (int i = 4; i < 16; i++) m_codes[i] = i == 5 ? 60 : i * 3;
    m_cnt = 16;
    line(420, 1'b1);
    line(445, 1'b1);
    cm(3);
    check("busy before reset", commit_busy, 1);
    do_reset();
    step(0, 480, 1'b0);
    check("busy after reset swap", commit_busy, 0);
    line(400, 1'b1);
    line(420, 1'b1);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
